skid_reg_en: RTL and testbench



---
 rtl/skid_reg_pkg.sv | 25 ++
 rtl/reg_en_rst.sv | 25 ++
 rtl/skid_reg_en.sv | 102 ++++++++++
 tb/tb_skid_reg_en.sv | 123 ++++++++++++
 4 files changed

// File: rtl/skid_reg_pkg.sv
// Shared types for the skid_reg_en elastic register: occupancy state and count encodings.
package skid_reg_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

  localparam logic [1:0] CountEmpty = 2'd0;
  localparam logic [1:0] CountOne   = 2'd1;
  localparam logic [1:0] CountFull  = 2'd2;

  function automatic logic [1:0] state_count(skid_state_e s);
    logic [1:0] c;
    c = CountEmpty;
    case (s)
      StOne:   c = CountOne;
      StFull:  c = CountFull;
      default: c = CountEmpty;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_en_rst.sv
// WIDTH-bit register with load enable and synchronous active-high reset to RESET_VAL.
module reg_en_rst #(
  parameter int unsigned          WIDTH     = 16,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RESET_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/skid_reg_en.sv
// Two-entry valid/ready elastic register (main + skid slot) with flush and occupancy count.
module skid_reg_en
  import skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_msg,
  input  logic             flush,
  output logic [1:0]       count
);

  skid_state_e      state_q, state_d;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             in_fire, out_fire;

  // Ready and valid come only from registered state, so no input-to-ready path exists.
  assign in_rdy   = (state_q != StFull) & ~reset;
  assign out_val  = (state_q != StEmpty) & ~reset;
  assign count    = reset ? CountEmpty : state_count(state_q);
  assign out_msg  = main_q;
  assign in_fire  = in_val & in_rdy;
  assign out_fire = out_val & out_rdy;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_msg;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StOne;
          main_en = 1'b1;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          state_d = StFull;
          skid_en = 1'b1;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_fire) begin
          state_d = StOne;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush drops all entries but leaves the data registers untouched.
    if (flush) begin
      state_d = StEmpty;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  reg_en_rst #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk_i(clk),
    .rst_i(reset),
    .en_i (main_en),
    .d_i  (main_d),
    .q_o  (main_q)
  );

  reg_en_rst #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_skid (
    .clk_i(clk),
    .rst_i(reset),
    .en_i (skid_en),
    .d_i  (in_msg),
    .q_o  (skid_q)
  );

endmodule

// File: tb/tb_skid_reg_en.sv
// Bench for skid_reg_en: directed scenarios plus random traffic against a queue-based model.
module tb_skid_reg_en;

  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = 16'hABCD;

  logic         clk = 1'b0;
  logic         reset, in_val, in_rdy, out_val, out_rdy, flush;
  logic [W-1:0] in_msg, out_msg;
  logic [1:0]   count;

  always #5 clk = ~clk;

  skid_reg_en #(
    .WIDTH    (W),
    .RESET_VAL(RV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .in_msg (in_msg),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg),
    .flush  (flush),
    .count  (count)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] q[$];
  bit           fresh   = 1'b0;  // main still holds RESET_VAL since the last reset

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, advance model at posedge.
  task automatic cycle(input bit rst, input bit iv, input logic [W-1:0] m, input bit ordy,
                       input bit fl);
    bit exp_rdy, exp_val;
    @(negedge clk);
    reset   = rst;
    in_val  = iv;
    in_msg  = m;
    out_rdy = ordy;
    flush   = fl;
    #1;
    exp_rdy = !rst && (q.size() < 2);
    exp_val = !rst && (q.size() > 0);
    check_eq("in_rdy", in_rdy, exp_rdy);
    check_eq("out_val", out_val, exp_val);
    check_eq("count", count, rst ? 0 : q.size());
    if (exp_val) check_eq("out_msg", out_msg, q[0]);
    else if (fresh && !rst) check_eq("out_msg_rst", out_msg, RV);
    @(posedge clk);
    if (rst) begin
      q.delete();
      fresh = 1'b1;
    end else begin
      if (exp_val && ordy) void'(q.pop_front());
      if (fl) q.delete();
      else if (iv && exp_rdy) begin
        q.push_back(m);
        fresh = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_val = 1'b0; in_msg = '0; out_rdy = 1'b0; flush = 1'b0;
    // Reset and idle
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    // Streaming 1..4 with consumer always ready
    for (int i = 1; i <= 4; i++) cycle(0, 1, 16'(i), 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    // Stall: 5,6 fill both slots, then drain
    cycle(0, 1, 16'd5, 0, 0);
    cycle(0, 1, 16'd6, 0, 0);
    cycle(0, 1, 16'd99, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    // FULL, then consumer ready with producer pushing every cycle
    cycle(0, 1, 16'd10, 0, 0);
    cycle(0, 1, 16'd11, 0, 0);
    for (int i = 12; i < 20; i++) cycle(0, 1, 16'(i), 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    // Flush while FULL with a concurrent input, then 7 alone
    cycle(0, 1, 16'd20, 0, 0);
    cycle(0, 1, 16'd21, 0, 0);
    cycle(0, 1, 16'd22, 0, 1);
    cycle(0, 1, 16'd7, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    // Reset while FULL holding 8,9
    cycle(0, 1, 16'd8, 0, 0);
    cycle(0, 1, 16'd9, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 100) == 0, ($urandom % 4) != 0, 16'($urandom),
            ($urandom % 3) != 0, ($urandom % 25) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
